// File: rtl/sap_controller_if.sv
// Control-word bundle between the SAP controller-sequencer and the datapath.
// The controller (master) receives the IR opcode nibble and drives every
// control line, the halt flag and the ring-state view; the datapath (slave)
// sees the opposite directions.
`timescale 1ns/1ps

interface sap_controller_if;
    logic [3:0] opcode;
    logic       Cp;
    logic       Ep;
    logic       Lm;
    logic       Ce;
    logic       Li;
    logic       Ei;
    logic       La;
    logic       Ea;
    logic       Su;
    logic       Eu;
    logic       Lb;
    logic       Lo;
    logic       hlt;
    logic [5:0] t_state;

    modport master (
        input  opcode,
        output Cp, Ep, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo,
        output hlt, t_state
    );

    modport slave (
        output opcode,
        input  Cp, Ep, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo,
        input  hlt, t_state
    );
endinterface

// File: rtl/sap_controller.sv
// SAP controller-sequencer: a six-state one-hot ring (T1..T6) plus a HALT
// state, and an opcode decoder producing the per-cycle control word.
// Fetch occupies T1..T3 for every instruction; the opcode is decoded only in
// T4..T6 because the IR is loaded at the T3->T4 edge.
`timescale 1ns/1ps

module sap_controller (
    input  logic             clk,
    input  logic             clr,
    sap_controller_if.master bus
);

    // HALT is the all-zero encoding so t_state can show the register directly.
    typedef enum logic [5:0] {
        HALT = 6'b000000,
        T1   = 6'b000001,
        T2   = 6'b000010,
        T3   = 6'b000100,
        T4   = 6'b001000,
        T5   = 6'b010000,
        T6   = 6'b100000
    } state_t;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_t;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_t;

    state_t state;
    ctrl_t  ctrl;

    // Ring advance; clr wins over everything, HLT diverts T4 into HALT.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values and simulation matches the synthesized logic.
        if (clr) begin
            state <= T1;
        end else begin
            case (state)
                T1:      state <= T2;
                T2:      state <= T3;
                T3:      state <= T4;
                T4:      state <= (bus.opcode == OP_HLT) ? HALT : T5;
                T5:      state <= T6;
                T6:      state <= T1;
                HALT:    state <= HALT;
                default: state <= T1;  // not one-hot: recover to a clean fetch
            endcase
        end
    end

    // Control word decode from registered state and opcode, silenced during clr.
    always_comb begin
        // NOTE: default every field first so no path through the case leaves a
        // bit unassigned, which would otherwise infer a latch.
        ctrl = '0;
        if (!clr) begin
            case (state)
                T1: begin
                    ctrl.ep = 1'b1;
                    ctrl.lm = 1'b1;
                end
                T2: ctrl.cp = 1'b1;
                T3: begin
                    ctrl.ce = 1'b1;
                    ctrl.li = 1'b1;
                end
                T4: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ctrl.ei = 1'b1;
                            ctrl.lm = 1'b1;
                        end
                        OP_OUT: begin
                            ctrl.ea = 1'b1;
                            ctrl.lo = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (bus.opcode)
                        OP_LDA: begin
                            ctrl.ce = 1'b1;
                            ctrl.la = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.ce = 1'b1;
                            ctrl.lb = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (bus.opcode)
                        OP_ADD: begin
                            ctrl.eu = 1'b1;
                            ctrl.la = 1'b1;
                        end
                        OP_SUB: begin
                            ctrl.su = 1'b1;
                            ctrl.eu = 1'b1;
                            ctrl.la = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.Cp      = ctrl.cp;
    assign bus.Ep      = ctrl.ep;
    assign bus.Lm      = ctrl.lm;
    assign bus.Ce      = ctrl.ce;
    assign bus.Li      = ctrl.li;
    assign bus.Ei      = ctrl.ei;
    assign bus.La      = ctrl.la;
    assign bus.Ea      = ctrl.ea;
    assign bus.Su      = ctrl.su;
    assign bus.Eu      = ctrl.eu;
    assign bus.Lb      = ctrl.lb;
    assign bus.Lo      = ctrl.lo;
    assign bus.hlt     = (state == HALT) && !clr;
    assign bus.t_state = state;

endmodule

// File: doc/sap_controller.md
# sap_controller

Controller-sequencer for the 4-bit SAP datapath. A six-state one-hot ring counter (T1–T6) and an opcode decoder produce the per-cycle control word for the program counter, MAR, RAM, instruction register, accumulator, adder/subtractor, B register and output register. It executes LDA, ADD, SUB, OUT and HLT on one clock and stops permanently on HLT until reset.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  synchronous, active-high reset.
- opcode  in  4  upper nibble of the instruction register; valid from T4 to T6.
- Cp  out  1  program-counter increment.
- Ep  out  1  program-counter drive onto the bus.
- Lm  out  1  MAR load.
- Ce  out  1  RAM drive onto the bus.
- Li  out  1  IR load.
- Ei  out  1  IR address nibble drive onto the bus.
- La  out  1  accumulator load.
- Ea  out  1  accumulator drive onto the bus.
- Su  out  1  adder/subtractor mode: 1 = subtract.
- Eu  out  1  adder/subtractor drive onto the bus.
- Lb  out  1  B register load.
- Lo  out  1  output register load.
- hlt  out  1  processor halted.
- t_state  out  6  one-hot ring state; bit 0 = T1, bit 5 = T6; all zeros in HALT.
- All control outputs are active-high. Datapath blocks invert where needed.

## Operation
- States are T1 to T6 (one-hot) plus HALT. Normal advance: T1→T2→…→T6→T1. Every instruction takes exactly 6 cycles, with no early exit.
- Fetch cycle, identical for all opcodes:
  - T1: Ep, Lm.
  - T2: Cp.
  - T3: Ce, Li.
- Execute cycle (T4, T5, T6):
  - LDA 0000: T4 Ei, Lm; T5 Ce, La; T6 no controls.
  - ADD 0001: T4 Ei, Lm; T5 Ce, Lb; T6 Eu, La.
  - SUB 0010: T4 Ei, Lm; T5 Ce, Lb; T6 Su, Eu, La.
  - OUT 1110: T4 Ea, Lo; T5 and T6 no controls.
  - HLT 1111: T4 asserts no controls. Next state is HALT instead of T5.
  - Any other opcode is a NOP: no controls in T4–T6, and the ring still completes.
- Control word is combinational from the registered state and opcode.
- At most one bus driver (Ep, Ce, Ei, Ea, Eu) is asserted in any cycle. The bench asserts this every cycle.
- HALT:
  - All controls are 0, hlt = 1, t_state = 000000.
  - The block holds in HALT indefinitely. Opcode changes are ignored. Only clr exits HALT.

## Timing
- Reset:
  - clr sampled high at a rising edge: next state = T1.
  - While clr is high, all control outputs and hlt are forced to 0.
  - t_state shows the registered state.
- First cycle after clr deasserts: T1, so Ep = Lm = 1 and t_state = 000001.
- Loads take effect at the rising edge that ends the cycle in which they are asserted.
  - Example: Li in T3 captures the instruction at the T3→T4 edge.
  - opcode is therefore stable by T4. It is not required in T1–T3, and the block does not decode it there.
- hlt rises in the first cycle in HALT, i.e. the cycle after the T4 edge with opcode 1111.
- clr asserted mid-instruction (any of T1–T6): controls drop to 0 that same cycle, and T1 follows at the next edge. The partial instruction is abandoned.
- clr while in HALT: next state T1 and hlt = 0 after the edge.
- clr has priority over every transition, including T4+HLT.
- Ring wrap: T6→T1 is unconditional except under clr.
- Illegal state (not one-hot, not HALT): next state T1.

## Test plan
- Reset then free-run with opcode = 0000 for 12 cycles: t_state sequence 000001, 000010, 000100, 001000, 010000, 100000, then repeats. Cp is high only in cycles 2 and 8.
- ADD (opcode 0001): T4 shows Ei=Lm=1; T5 shows Ce=Lb=1; T6 shows Eu=La=1 with Su=0. SUB (0010) gives the identical pattern except Su=1 in T6.
- OUT (1110): T4 shows Ea=Lo=1, and all controls are 0 in T5 and T6. Opcode 0111 gives all controls 0 in T4–T6 with the ring unchanged.
- HLT (1111) at T4: the next cycle has hlt=1, t_state=000000 and all controls 0. The block holds for 20 cycles while opcode toggles. clr for 1 cycle then gives T1 with Ep=Lm=1 and hlt=0.
- clr asserted during T5 of LDA: Ce=La=0 in that cycle, and the next cycle is T1.
- Every cycle of a random opcode run: at most one of Ep, Ce, Ei, Ea, Eu is high.
